// File: rtl/hilo_mult_unit_if.sv
// hilo_mult_unit_if: decoder-to-HI/LO-unit request and result bundle
interface hilo_mult_unit_if #(parameter int WIDTH = 32);
  logic             HiLoWrite;
  logic [4:0]       ALUCtl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic [WIDTH-1:0] MulResult;
  modport master (output HiLoWrite, ALUCtl, A, B, input Busy, Done, HiOut, LoOut, MulResult);
  modport slave (input HiLoWrite, ALUCtl, A, B, output Busy, Done, HiOut, LoOut, MulResult);
endinterface

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: HI/LO registers with a sign-magnitude shift-add multiplier
module hilo_mult_unit #(parameter int WIDTH = 32) (
  input logic Clk,
  input logic Reset,
  hilo_mult_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [4:0] OP_MULT = 5'b00101;
  localparam logic [4:0] OP_MADD = 5'b01100;
  localparam logic [4:0] OP_MSUB = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b11000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MTLO = 5'b10011;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mul_q, mul_d, mplr_q, mplr_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic               sign_q, sign_d, done_q, done_d;
  logic               accept, start, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] p, hilo, acc;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_q   <= mul_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    accept = bus.HiLoWrite && state_q == IDLE;
    start = accept && (bus.ALUCtl == OP_MULT || bus.ALUCtl == OP_MADD ||
                       bus.ALUCtl == OP_MSUB || bus.ALUCtl == OP_MUL);
    last = cnt_q == CW'(WIDTH - 1);
    state_d = (state_q == IDLE && start) ? RUN :
              (state_q == RUN && last)   ? FIN :
              (state_q == FIN)           ? IDLE : state_q;
  end
  // Multiply on magnitudes, then restore the sign once at commit time
  always_comb begin
    a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
    b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
    p = sign_q ? -prod_q : prod_q;
    hilo = {hi_q, lo_q};
    acc = op_q == OP_MADD ? hilo + p : op_q == OP_MSUB ? hilo - p : p;
    hi_d = (accept && bus.ALUCtl == OP_MTHI) ? bus.A : hi_q;
    lo_d = (accept && bus.ALUCtl == OP_MTLO) ? bus.A : lo_q;
    mul_d = mul_q;
    mcand_d = mcand_q;
    mplr_d = mplr_q;
    prod_d = prod_q;
    cnt_d = cnt_q;
    op_d = op_q;
    sign_d = sign_q;
    done_d = state_q == FIN;
    if (start) begin
      mcand_d = {{WIDTH{1'b0}}, a_mag};
      mplr_d = b_mag;
      prod_d = '0;
      cnt_d = '0;
      op_d = bus.ALUCtl;
      sign_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
    end
    if (state_q == RUN) begin
      prod_d = prod_q + (mplr_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplr_d = mplr_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == FIN) begin
      if (op_q == OP_MUL) mul_d = p[WIDTH-1:0];
      else {hi_d, lo_d} = acc;
    end
  end
  always_comb begin
    bus.Busy = state_q == RUN || state_q == FIN;
    bus.Done = done_q;
    bus.HiOut = hi_q;
    bus.LoOut = lo_q;
    bus.MulResult = mul_q;
  end
endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: random and directed checks against a countdown-based HI/LO model
module tb_hilo_mult_unit;
  localparam logic [4:0] OP_MULT = 5'b00101;
  localparam logic [4:0] OP_MADD = 5'b01100;
  localparam logic [4:0] OP_MSUB = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b11000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MTLO = 5'b10011;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic cmp_en = 1'b0;
  int checks = 0;
  int passes = 0;
  hilo_mult_unit_if #(.WIDTH(32)) bus();
  hilo_mult_unit #(.WIDTH(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));
  always #5 Clk = ~Clk;
  logic [31:0] m_hi, m_lo, m_mul;
  logic [63:0] m_p;
  logic [4:0]  m_op;
  logic        m_done;
  int          m_left;
  function automatic logic [63:0] commit(logic [4:0] op, logic [63:0] hl, logic [63:0] p);
    return op == OP_MADD ? hl + p : op == OP_MSUB ? hl - p : p;
  endfunction
  always @(posedge Clk) begin
    if (Reset) begin
      m_hi <= 0; m_lo <= 0; m_mul <= 0; m_left <= 0; m_done <= 0; m_p <= 0; m_op <= 0;
    end else begin
      m_done <= m_left == 1;
      if (m_left == 1) begin
        if (m_op == OP_MUL) m_mul <= m_p[31:0];
        else {m_hi, m_lo} <= commit(m_op, {m_hi, m_lo}, m_p);
      end
      if (m_left > 0) m_left <= m_left - 1;
      else if (bus.HiLoWrite) begin
        if (bus.ALUCtl == OP_MTHI) m_hi <= bus.A;
        else if (bus.ALUCtl == OP_MTLO) m_lo <= bus.A;
        else if (bus.ALUCtl inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL}) begin
          m_left <= 33;
          m_op <= bus.ALUCtl;
          m_p <= 64'(longint'($signed(bus.A)) * longint'($signed(bus.B)));
        end
      end
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  always @(negedge Clk) begin
    if (cmp_en) begin
      check("busy", 64'(bus.Busy), 64'(m_left > 0));
      check("done", 64'(bus.Done), 64'(m_done));
      check("hi", 64'(bus.HiOut), 64'(m_hi));
      check("lo", 64'(bus.LoOut), 64'(m_lo));
      check("busy_done_excl", 64'(bus.Busy && bus.Done), 64'(0));
      if (m_done) check("mulresult", 64'(bus.MulResult), 64'(m_mul));
    end
  end
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.HiLoWrite = 1'b1; bus.ALUCtl = op; bus.A = a; bus.B = b;
    @(negedge Clk);
    bus.HiLoWrite = 1'b0;
  endtask
  task automatic wait_done(output int busy_cycles);
    logic got;
    got = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Done) begin got = 1'b1; break; end
      if (bus.Busy) busy_cycles++;
      @(negedge Clk);
    end
    check("done_timeout", 64'(got), 64'(1));
  endtask
  function automatic logic [31:0] pick();
    int r;
    r = int'($urandom_range(0, 5));
    return r == 0 ? 32'h8000_0000 : r == 1 ? 32'hFFFF_FFFF : r == 2 ? 32'h0 : $urandom;
  endfunction
  initial begin
    int bc, dcnt;
    logic [4:0] codes [8];
    codes = '{OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_MTHI, OP_MTLO, 5'b00000, 5'b11111};
    bus.HiLoWrite = 1'b0; bus.ALUCtl = '0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    cmp_en = 1'b1;
    check("reset_hi", 64'(bus.HiOut), 64'(0));
    check("reset_lo", 64'(bus.LoOut), 64'(0));
    check("reset_busy", 64'(bus.Busy), 64'(0));
    check("reset_mul", 64'(bus.MulResult), 64'(0));
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(bc);
    check("mult_busy_cycles", 64'(bc), 64'(33));
    check("mult_hi", 64'(bus.HiOut), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.LoOut), 64'hFFFF_FFEB);
    @(negedge Clk);
    do_op(OP_MTLO, 32'h10, 0);
    do_op(OP_MTHI, 32'h0, 0);
    check("mtlo_lo", 64'(bus.LoOut), 64'h10);
    do_op(OP_MADD, 32'd2, 32'd3);
    wait_done(bc);
    check("madd_hi", 64'(bus.HiOut), 64'h0);
    check("madd_lo", 64'(bus.LoOut), 64'h16);
    @(negedge Clk);
    do_op(OP_MSUB, 32'h8000_0000, 32'd1);
    wait_done(bc);
    check("msub_min_hi", 64'(bus.HiOut), 64'h0);
    check("msub_min_lo", 64'(bus.LoOut), 64'h8000_0016);
    @(negedge Clk);
    do_op(OP_MTHI, 32'h0, 0);
    do_op(OP_MTLO, 32'd5, 0);
    do_op(OP_MSUB, 32'd2, 32'd3);
    wait_done(bc);
    check("msub_wrap_hi", 64'(bus.HiOut), 64'hFFFF_FFFF);
    check("msub_wrap_lo", 64'(bus.LoOut), 64'hFFFF_FFFF);
    @(negedge Clk);
    do_op(OP_MUL, 32'h0001_0000, 32'h0001_0003);
    wait_done(bc);
    check("mul_result", 64'(bus.MulResult), 64'h0003_0000);
    check("mul_hi_kept", 64'(bus.HiOut), 64'hFFFF_FFFF);
    check("mul_lo_kept", 64'(bus.LoOut), 64'hFFFF_FFFF);
    @(negedge Clk);
    do_op(OP_MULT, 32'd3, 32'd4);
    repeat (9) @(negedge Clk);
    do_op(OP_MTLO, 32'h55, 0);
    check("mtlo_ignored", 64'(bus.LoOut), 64'hFFFF_FFFF);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done) dcnt++;
      @(negedge Clk);
    end
    check("abort_no_done", 64'(dcnt), 64'(0));
    check("abort_hi", 64'(bus.HiOut), 64'h0);
    check("abort_lo", 64'(bus.LoOut), 64'h0);
    check("abort_busy", 64'(bus.Busy), 64'(0));
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(bc);
    check("minmin_hi", 64'(bus.HiOut), 64'h4000_0000);
    check("minmin_lo", 64'(bus.LoOut), 64'h0);
    do_op(OP_MULT, 32'd6, 32'd7);
    check("b2b_busy", 64'(bus.Busy), 64'(1));
    wait_done(bc);
    check("b2b_lo", 64'(bus.LoOut), 64'd42);
    for (int i = 0; i < 1500; i++) begin
      bus.HiLoWrite = ($urandom_range(0, 1) == 1);
      bus.ALUCtl = codes[$urandom_range(0, 7)];
      bus.A = pick();
      bus.B = pick();
      @(negedge Clk);
    end
    bus.HiLoWrite = 1'b0;
    repeat (40) @(negedge Clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Sits directly downstream of the ALU control decoder in the EX stage, alongside the main ALU.
- Consumes the decoder's 5-bit ALU control code and HI/LO write-enable strobe.
- Owns the architectural HI/LO registers and executes mult, madd, msub and mul with a 32-iteration shift-add multiplier; executes mthi and mtlo in a single cycle.
- Exposes HI/LO combinationally for mfhi/mflo, and raises Busy so the hazard unit stalls the pipeline while a multiply is in flight.

Parameters:
WIDTH, 32, operand and HI/LO register width; the multiplier performs WIDTH iterations.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
HiLoWrite  in  1  request strobe from the ALU control decoder; the request is accepted only when Busy=0
ALUCtl  in  5  operation code: 00101 mult, 01100 madd, 01101 msub, 11000 mul, 10001 mthi, 10011 mtlo
A  in  WIDTH  rs operand; also the mthi/mtlo source
B  in  WIDTH  rt operand
Busy  out  1  multiply in progress; upstream must hold the instruction
Done  out  1  one-cycle pulse when a multiply-class operation completes
HiOut  out  WIDTH  current HI register
LoOut  out  WIDTH  current LO register
MulResult  out  WIDTH  low word of the last mul product, for rd writeback; valid while Done=1

Behaviour:
- Reset at a clock edge with Reset=1:
  - HI, LO, MulResult, internal product and counter all go to 0; Busy=0, Done=0; state=IDLE.
  - Reset takes priority over every other input, and a multiply in flight is aborted with no HI/LO update.
- States:
  - IDLE: the unit accepts requests.
  - RUN: the multiplier iterates.
  - FIN: the unit commits the result.
- IDLE, HiLoWrite=1, ALUCtl=mthi: HI<=A at the edge. LO is unchanged, Busy stays 0, Done stays 0.
- IDLE, HiLoWrite=1, ALUCtl=mtlo: LO<=A at the edge. HI is unchanged, Busy stays 0, Done stays 0.
- IDLE, HiLoWrite=1, ALUCtl in {mult, madd, msub, mul}, at acceptance edge E:
  - Latch |A| and |B| as unsigned magnitudes; latch sign = A[WIDTH-1]^B[WIDTH-1].
  - Latch the op code; clear the 2*WIDTH product and the counter.
  - Go to RUN. Busy=1 from E+1.
- RUN: each edge performs one shift-add iteration and increments the counter. After WIDTH edges (E+WIDTH), go to FIN.
- FIN, at edge E+WIDTH+1:
  - Form the signed product P = sign ? -mag : mag.
  - mult: {HI,LO}<=P.
  - madd: {HI,LO}<={HI,LO}+P, mod 2^(2*WIDTH).
  - msub: {HI,LO}<={HI,LO}-P, mod 2^(2*WIDTH).
  - mul: MulResult<=P[WIDTH-1:0]; HI/LO are unchanged.
  - Done=1 and Busy=0 during the cycle following this edge, then return to IDLE.
- Total multiply latency is WIDTH+1 Busy cycles. Done is never high in the same cycle as Busy.
- HiLoWrite=1 during Busy=1 is ignored: no effect, no queueing. A back-to-back request in the Done cycle is accepted normally.
- HiLoWrite=1 with any other ALUCtl code: no state change.
- HiLoWrite=0: no state change, whatever the value of ALUCtl.
- HiOut and LoOut are direct register outputs. mfhi/mflo read them with no forwarding inside this block.
- Overflow in madd/msub wraps silently. Operand -2^(WIDTH-1) is handled correctly: its magnitude is held in WIDTH bits, unsigned.

Test Plan:
- Reset, then mult A=0xFFFFFFFD (-3), B=7 -> Busy high for 33 cycles; Done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- mtlo A=0x10, mthi A=0, then madd A=2, B=3 -> HI=0, LO=0x16. Then msub A=0x80000000, B=1 -> HI=0x00000000, LO=0x80000016.
- mthi A=0, mtlo A=5, then msub A=2, B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF (wraps to -1).
- mul A=0x00010000, B=0x00010003 -> MulResult=0x00030000 during Done; HI/LO keep their prior values.
- Start mult, pulse mtlo A=0x55 at cycle 10 of Busy, then assert Reset at cycle 20 -> the mtlo is ignored; after Reset, HI=LO=0, Busy=0, Done never pulses.
- Issue mult A=0x80000000, B=0x80000000, then a second mult in the Done cycle -> first result HI=0x40000000, LO=0; second request accepted, Busy rises on the next cycle.
